// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-byte ALU sequencer: FSM states,
// the op/mode encodings the CPU uses for wide ADD/SUB/XOR, and operand-width checks.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD   = 4'b1001;
    localparam logic       MODE_ADD = 1'b0;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic       MODE_SUB = 1'b0;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic       MODE_XOR = 1'b1;

    localparam int NBYTES_MIN = 1;
    localparam int NBYTES_MAX = 4;

    function automatic bit nbytes_legal(input int n);
        return (n >= NBYTES_MIN) && (n <= NBYTES_MAX);
    endfunction

    // Byte index needs at least one bit even for single-byte operands.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_seq_slicer.sv
// Operand latch, byte selection by index and result byte assembly.
// Latency: operands usable the cycle after load; result byte visible the cycle after cap.
// Backpressure: none; load/cap are qualified by the owning FSM.
module alu_seq_slicer
    import alu_seq_pkg::*;
#(
    parameter  int NBYTES = 2,
    localparam int W      = 8 * NBYTES,
    localparam int IW     = idx_width(NBYTES)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          load,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    input  logic          cap,
    input  logic [IW-1:0] idx,
    input  logic [7:0]    res_byte,
    output logic [7:0]    a_byte,
    output logic [7:0]    b_byte,
    output logic [W-1:0]  result
);

    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [7:0]   res_q [NBYTES];
    logic [7:0]   res_d [NBYTES];
    logic [7:0]   a_bytes [NBYTES];
    logic [7:0]   b_bytes [NBYTES];

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        if (load) begin
            a_d = a_in;
            b_d = b_in;
        end
        if (cap) begin
            res_d[idx] = res_byte;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '{default: '0};
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
        end
    end

    for (genvar g = 0; g < NBYTES; g++) begin : g_bytes
        assign a_bytes[g]         = a_q[8*g +: 8];
        assign b_bytes[g]         = b_q[8*g +: 8];
        assign result[8*g +: 8]   = res_q[g];
    end

    assign a_byte = a_bytes[idx];
    assign b_byte = b_bytes[idx];

endmodule

// File: rtl/alu_seq.sv
// Sequences one NBYTES-wide op through an external 8-bit ALU, LSB first, chaining carry.
// Latency: rsp_valid NBYTES+1 cycles after accept; optional ALU_SEQ_PIPE_EN overlaps response and next accept.
// Backpressure: req_ready low while busy; response held stable until rsp_ready.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int NBYTES = 2,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic         req_mode,
    input  logic         req_cin,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_carry,
    output logic         rsp_zero,
    output logic         rsp_neg,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic [3:0]   alu_op,
    output logic         alu_mode,
    output logic         alu_cf_in,
    input  logic [7:0]   alu_out,
    input  logic         alu_cf_out
);

    localparam int            IW   = idx_width(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    if (!nbytes_legal(NBYTES)) begin : g_bad_nbytes
        $error("alu_seq: NBYTES must be in 1..4");
    end

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    op_q, op_d;
    logic          mode_q, mode_d;
    logic          cin_q, cin_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;
    logic          neg_q, neg_d;
    logic          accept;
    logic          in_exec;
    logic [7:0]    a_byte, b_byte;

    assign in_exec = (state_q == ST_EXEC);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        mode_d    = mode_q;
        cin_d     = cin_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        req_ready = 1'b0;
        alu_a     = 8'd0;
        alu_b     = 8'd0;
        alu_op    = 4'd0;
        alu_mode  = 1'b0;
        alu_cf_in = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = ST_EXEC;
                    idx_d   = '0;
                end
            end
            ST_EXEC: begin
                alu_a    = a_byte;
                alu_b    = b_byte;
                alu_op   = op_q;
                alu_mode = mode_q;
                // Logic ops never see or report a carry.
                alu_cf_in = mode_q ? 1'b0 : ((idx_q == '0) ? cin_q : carry_q);
                carry_d   = alu_cf_out & ~mode_q;
                zero_d    = ((idx_q == '0) ? 1'b1 : zero_q) & (alu_out == 8'd0);
                neg_d     = alu_out[7];
                if (idx_q == LAST) begin
                    state_d = ST_RESP;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_RESP: begin
`ifdef ALU_SEQ_PIPE_EN
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    state_d = req_valid ? ST_EXEC : ST_IDLE;
                    idx_d   = '0;
                end
`else
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        accept = req_valid && req_ready;
        if (accept) begin
            op_d   = req_op;
            mode_d = req_mode;
            cin_d  = req_cin;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= 4'd0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            mode_q  <= mode_d;
            cin_q   <= cin_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    alu_seq_slicer #(
        .NBYTES (NBYTES)
    ) u_slicer (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (accept),
        .a_in     (req_a),
        .b_in     (req_b),
        .cap      (in_exec),
        .idx      (idx_q),
        .res_byte (alu_out),
        .a_byte   (a_byte),
        .b_byte   (b_byte),
        .result   (rsp_result)
    );

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;
    assign rsp_neg   = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (NBYTES=2) with an attached 8-bit ALU model and a wide-arithmetic reference.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         req_valid, req_ready;
    logic [3:0]   req_op;
    logic         req_mode, req_cin;
    logic [W-1:0] req_a, req_b;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry, rsp_zero, rsp_neg;
    logic [7:0]   alu_a, alu_b, alu_out;
    logic [3:0]   alu_op;
    logic         alu_mode, alu_cf_in, alu_cf_out;
    logic [8:0]   s9;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [3:0]   exp_op;
    logic         exp_mode, exp_cin, exp_c, exp_z, exp_n;
    logic [W-1:0] exp_a, exp_b, exp_res;

    alu_seq #(.NBYTES(NB)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_mode   (req_mode),
        .req_cin    (req_cin),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_mode   (alu_mode),
        .alu_cf_in  (alu_cf_in),
        .alu_out    (alu_out),
        .alu_cf_out (alu_cf_out)
    );

    always #5 clk = ~clk;

    // Byte ALU; logic-mode carry out is driven high so any leak into rsp_carry shows.
    always_comb begin
        alu_out    = 8'd0;
        alu_cf_out = 1'b0;
        s9         = 9'd0;
        if (alu_mode == MODE_XOR && alu_op == OP_XOR) begin
            alu_out    = alu_a ^ alu_b;
            alu_cf_out = 1'b1;
        end else if (alu_mode == MODE_ADD && alu_op == OP_ADD) begin
            s9         = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cf_in};
            alu_out    = s9[7:0];
            alu_cf_out = s9[8];
        end else if (alu_mode == MODE_SUB && alu_op == OP_SUB) begin
            s9         = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cf_in};
            alu_out    = s9[7:0];
            alu_cf_out = s9[8];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_exp(input logic [3:0] op, input logic mode, input logic cin,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned ai, bi, ci, m, s;
        ai = a; bi = b; ci = cin; m = 64'd1 << W;
        exp_op = op; exp_mode = mode; exp_cin = cin; exp_a = a; exp_b = b;
        if (mode) begin
            exp_res = a ^ b;
            exp_c   = 1'b0;
        end else if (op == OP_ADD) begin
            s       = ai + bi + ci;
            exp_res = W'(s % m);
            exp_c   = (s >= m);
        end else begin
            s       = (ai + m - bi - ci) % m;
            exp_res = W'(s);
            exp_c   = (ai < bi + ci);
        end
        exp_z = (exp_res == '0);
        exp_n = exp_res[W-1];
    endtask

    // Carry/borrow entering byte k, from the low 8k bits of the operands.
    function automatic logic cf_into(input int k);
        longint unsigned m, al, bl, ci;
        if (exp_mode) return 1'b0;
        if (k == 0) return exp_cin;
        m  = 64'd1 << (8 * k);
        al = exp_a % m; bl = exp_b % m; ci = exp_cin;
        if (exp_op == OP_ADD) return (al + bl + ci) >= m;
        return al < (bl + ci);
    endfunction

    task automatic start_op(input logic [3:0] op, input logic mode, input logic cin,
                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        ok = 1'b0;
        req_op = op; req_mode = mode; req_cin = cin; req_a = a; req_b = b;
        req_valid = 1'b1;
        set_exp(op, mode, cin, a, b);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", 32'(ok), 32'd1);
        @(posedge clk);
    endtask

    task automatic check_rsp();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("result", 32'(rsp_result), 32'(exp_res));
        chk("carry", 32'(rsp_carry), 32'(exp_c));
        chk("zero", 32'(rsp_zero), 32'(exp_z));
        chk("neg", 32'(rsp_neg), 32'(exp_n));
    endtask

    task automatic wait_rsp();
        int lat;
        lat = 0;
        for (int k = 1; k <= NB + 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                rsp_ready = 1'b0;
            end
            if (k <= NB) begin
                chk("alu_a", 32'(alu_a), 32'(exp_a[8*(k-1) +: 8]));
                chk("alu_b", 32'(alu_b), 32'(exp_b[8*(k-1) +: 8]));
                chk("alu_op", 32'({alu_mode, alu_op}), 32'({exp_mode, exp_op}));
                chk("alu_cf_in", 32'(alu_cf_in), 32'(cf_into(k - 1)));
            end
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, NB + 1);
        check_rsp();
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("ready_idle", 32'(req_ready), 32'd1);
    endtask

    task automatic run_op(input logic [3:0] op, input logic mode, input logic cin,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        start_op(op, mode, cin, a, b);
        wait_rsp();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_rsp();
        end
        finish_rsp();
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] edges [4];
        edges[0] = '0; edges[1] = '1; edges[2] = 16'h00FF; edges[3] = 16'hFF00;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return W'($urandom);
    endfunction

    initial begin
        logic sticky;
        int   sel;
        req_valid = 1'b0; req_op = 4'd0; req_mode = 1'b0; req_cin = 1'b0;
        req_a = '0; req_b = '0; rsp_ready = 1'b0;

        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_flags", 32'({rsp_result, rsp_carry, rsp_zero, rsp_neg}), 32'd0);
        chk("rst_alu_drive", 32'({alu_a, alu_b, alu_op, alu_mode, alu_cf_in}), 32'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        run_op(OP_ADD, MODE_ADD, 1'b0, 16'h00FF, 16'h0001, 0);
        chk("add1_res", 32'(exp_res), 32'h0100);
        run_op(OP_ADD, MODE_ADD, 1'b0, 16'hFFFF, 16'h0001, 0);
        chk("add2_res", 32'({exp_c, exp_z, exp_res}), 32'h30000);
        run_op(OP_SUB, MODE_SUB, 1'b0, 16'h0000, 16'h0001, 0);
        chk("sub1_res", 32'({exp_c, exp_n, exp_res}), 32'h3FFFF);
        run_op(OP_SUB, MODE_SUB, 1'b0, 16'h0100, 16'h0001, 0);
        chk("sub2_res", 32'({exp_c, exp_res}), 32'h000FF);
        run_op(OP_XOR, MODE_XOR, 1'b1, 16'hA5A5, 16'hFFFF, 0);
        chk("xor_res", 32'({exp_c, exp_res}), 32'h05A5A);

        // Response held off for 5 cycles with another request waiting.
        start_op(OP_ADD, MODE_ADD, 1'b0, 16'h1234, 16'h4321);
        wait_rsp();
        req_op = OP_SUB; req_mode = MODE_SUB; req_cin = 1'b1;
        req_a = 16'h8000; req_b = 16'h0001; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_rsp();
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
`ifdef ALU_SEQ_PIPE_EN
        chk("pipe_req_ready", 32'(req_ready), 32'd1);
        set_exp(OP_SUB, MODE_SUB, 1'b1, 16'h8000, 16'h0001);
        @(posedge clk);
`else
        chk("nopipe_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_rsp_drop", 32'(rsp_valid), 32'd0);
        start_op(OP_SUB, MODE_SUB, 1'b1, 16'h8000, 16'h0001);
`endif
        wait_rsp();
        chk("sub3_res", 32'(exp_res), 32'h7FFE);
        finish_rsp();

        // Reset asserted while byte 1 is on the ALU.
        start_op(OP_ADD, MODE_ADD, 1'b0, 16'h1234, 16'h1111);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_alu_busy", 32'(alu_a), 32'h12);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
        sticky = 1'b0;
        repeat (6) begin
            @(negedge clk);
            sticky = sticky | rsp_valid;
        end
        chk("no_spurious_rsp", 32'(sticky), 32'd0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 2);
            case (sel)
                0:       run_op(OP_ADD, MODE_ADD, 1'($urandom), rand_operand(), rand_operand(), $urandom_range(0, 3));
                1:       run_op(OP_SUB, MODE_SUB, 1'($urandom), rand_operand(), rand_operand(), $urandom_range(0, 3));
                default: run_op(OP_XOR, MODE_XOR, 1'($urandom), rand_operand(), rand_operand(), $urandom_range(0, 3));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
